// File: rtl/cache_refill_if.sv
// CPU lookup port and memory refill port of the cache refill controller.
// Valid/ready: a transfer happens on a rising edge where valid & ready are both high; the
// requester holds valid and its payload stable until then, and may not retract valid early.
interface cache_refill_if #(
  parameter int ADDR_W = 11
);
  logic              cpu_req_valid;
  logic              cpu_req_ready;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_resp_valid;
  logic              cpu_resp_hit;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rsp_valid;

  modport master (
    output cpu_req_valid, cpu_addr, mem_req_ready, mem_rsp_valid,
    input  cpu_req_ready, cpu_resp_valid, cpu_resp_hit, mem_req_valid, mem_req_addr
  );

  modport slave (
    input  cpu_req_valid, cpu_addr, mem_req_ready, mem_rsp_valid,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_hit, mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Direct-mapped cache sequencer: tag/valid store, hit/miss lookup, line refill and flush.
// Optional saturating hit/miss counters are built only when CACHE_STATS_EN is defined.
module cache_refill_ctrl #(
  parameter int ADDR_W   = 11,
  parameter int INDEX_W  = 4,
  parameter int OFFSET_W = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  cache_refill_if.slave    bus,
  input  logic             flush,
  output logic             busy,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [2:0]       state_dbg
);
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES = 1 << INDEX_W;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << OFFSET_W) - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_MREQ   = 3'd2,
    S_MWAIT  = 3'd3,
    S_RESP   = 3'd4,
    S_FLUSH  = 3'd5
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic [LINES-1:0]    valid_q;
  logic [TAG_W-1:0]    tag_q [LINES];
  logic                hit_q;
  logic                flush_pend;
  logic [OFFSET_W-1:0] beat_cnt;
  logic [INDEX_W-1:0]  fcnt;
  logic [INDEX_W-1:0]  idx;
  logic [TAG_W-1:0]    tag;
  logic                lookup_hit;
  logic                last_beat;
  logic                accept;

  assign idx        = addr_q[INDEX_W+OFFSET_W-1:OFFSET_W];
  assign tag        = addr_q[ADDR_W-1:INDEX_W+OFFSET_W];
  assign lookup_hit = valid_q[idx] & (tag_q[idx] == tag);
  assign last_beat  = (state == S_MWAIT) & bus.mem_rsp_valid & (beat_cnt == '1);
  assign accept     = bus.cpu_req_valid & bus.cpu_req_ready;

  assign bus.cpu_req_ready  = (state == S_IDLE) & ~flush & ~flush_pend;
  assign bus.cpu_resp_valid = (state == S_RESP);
  assign bus.cpu_resp_hit   = (state == S_RESP) & hit_q;
  assign bus.mem_req_valid  = (state == S_MREQ);
  assign bus.mem_req_addr   = (state == S_MREQ) ? (addr_q & LINE_MASK) : '0;
  assign busy               = (state != S_IDLE);
  assign state_dbg          = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (flush | flush_pend) state_nxt = S_FLUSH;
        else if (accept)        state_nxt = S_LOOKUP;
      end
      S_LOOKUP: state_nxt = lookup_hit ? S_RESP : S_MREQ;
      S_MREQ:   if (bus.mem_req_ready) state_nxt = S_MWAIT;
      S_MWAIT:  if (last_beat) state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      S_FLUSH:  if (fcnt == '1) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      hit_q      <= 1'b0;
      flush_pend <= 1'b0;
      beat_cnt   <= '0;
      fcnt       <= '0;
      valid_q    <= '0;
      for (int i = 0; i < LINES; i++) tag_q[i] <= '0;
    end else begin
      if (accept) addr_q <= bus.cpu_addr;
      if (state == S_LOOKUP) hit_q <= lookup_hit;
      // A flush seen mid-transaction is remembered and serviced once back in IDLE.
      if (flush && state != S_IDLE && state != S_FLUSH) flush_pend <= 1'b1;
      else if (state == S_FLUSH && fcnt == '1)          flush_pend <= 1'b0;
      if (state == S_MREQ && bus.mem_req_ready)        beat_cnt <= '0;
      else if (state == S_MWAIT && bus.mem_rsp_valid)  beat_cnt <= beat_cnt + 1'b1;
      if (last_beat) begin
        tag_q[idx]   <= tag;
        valid_q[idx] <= 1'b1;
      end
      if (state == S_IDLE) fcnt <= '0;
      else if (state == S_FLUSH) begin
        valid_q[fcnt] <= 1'b0;
        fcnt          <= fcnt + 1'b1;
      end
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == S_RESP) begin
      if (hit_q) begin
        if (hit_count != '1) hit_count <= hit_count + 1'b1;
      end else begin
        if (miss_count != '1) miss_count <= miss_count + 1'b1;
      end
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: hit/miss, eviction, refill stall, flush, reset abort, stats.
module tb_cache_refill_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        busy;
  logic [15:0] hit_count;
  logic [15:0] miss_count;
  logic [2:0]  state_dbg;
  int          n_checks = 0;
  int          n_fail   = 0;

  logic        r_hit;
  int          r_nreq;
  logic [10:0] r_maddr;
  int          r_lat;
  logic        r_stable;
  logic        r_rdylow;

  always #5 clk = ~clk;

  cache_refill_if #(.ADDR_W(11)) bus();

  cache_refill_ctrl #(
    .ADDR_W(11), .INDEX_W(4), .OFFSET_W(2), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .flush(flush), .busy(busy),
    .hit_count(hit_count), .miss_count(miss_count), .state_dbg(state_dbg)
  );

  // Issue one lookup from IDLE and play the memory side until the response strobe.
  task automatic run_req(input logic [10:0] a, input int rdy_delay, input int flush_beat,
                         output logic hit, output int nreq, output logic [10:0] maddr,
                         output int lat, output logic stable, output logic rdy_low);
    int  g, waitc, beats;
    bit  phase;
    hit = 1'bx; nreq = 0; maddr = 'x; lat = 0; stable = 1'b1; rdy_low = 1'b1;
    g = 0; waitc = 0; beats = 0; phase = 1'b0;
    bus.cpu_addr = a;
    bus.cpu_req_valid = 1'b1;
    while (!bus.cpu_req_ready && g < 50) begin @(negedge clk); g++; end
    @(negedge clk);
    bus.cpu_req_valid = 1'b0;
    bus.cpu_addr = 11'h7ff;
    lat = 1;
    while (lat < 200) begin
      flush = 1'b0;
      if (bus.cpu_resp_valid) begin hit = bus.cpu_resp_hit; break; end
      if (bus.cpu_req_ready) rdy_low = 1'b0;
      if (bus.mem_req_ready && !bus.mem_req_valid) begin bus.mem_req_ready = 1'b0; phase = 1'b1; end
      bus.mem_rsp_valid = 1'b0;
      if (phase && beats < 4) begin
        bus.mem_rsp_valid = 1'b1;
        beats++;
        if (beats == flush_beat) flush = 1'b1;
      end
      if (bus.mem_req_valid) begin
        if (nreq == 0) maddr = bus.mem_req_addr;
        else if (bus.mem_req_addr !== maddr) stable = 1'b0;
        nreq++;
        if (waitc >= rdy_delay) bus.mem_req_ready = 1'b1;
        waitc++;
      end
      @(negedge clk);
      lat++;
    end
    bus.mem_rsp_valid = 1'b0;
    bus.mem_req_ready = 1'b0;
    flush = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    bus.cpu_req_valid = 1'b0; bus.cpu_addr = '0;
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (state_dbg !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    n_checks++; if (bus.cpu_resp_valid !== 1'b0 || bus.mem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_strobes: resp %b mem %b want 0 0", bus.cpu_resp_valid, bus.mem_req_valid); end
    n_checks++; if (bus.mem_req_addr !== 11'd0) begin n_fail++; $display("FAIL reset_maddr: got %0d want 0", bus.mem_req_addr); end
    n_checks++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_counts: got %0d/%0d want 0/0", hit_count, miss_count); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.cpu_req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.cpu_req_ready); end
  endtask

  task automatic test_hit_miss();
    @(negedge clk);
    run_req(11'd34, 0, 0, r_hit, r_nreq, r_maddr, r_lat, r_stable, r_rdylow);
    n_checks++; if (r_hit !== 1'b0) begin n_fail++; $display("FAIL miss34_hit: got %b want 0", r_hit); end
    n_checks++; if (r_maddr !== 11'd32) begin n_fail++; $display("FAIL miss34_addr: got %0d want 32", r_maddr); end
    n_checks++; if (r_lat !== 7) begin n_fail++; $display("FAIL miss34_latency: got %0d want 7", r_lat); end
    run_req(11'd34, 0, 0, r_hit, r_nreq, r_maddr, r_lat, r_stable, r_rdylow);
    n_checks++; if (r_hit !== 1'b1) begin n_fail++; $display("FAIL hit34_hit: got %b want 1", r_hit); end
    n_checks++; if (r_lat !== 2) begin n_fail++; $display("FAIL hit34_latency: got %0d want 2", r_lat); end
    n_checks++; if (r_nreq !== 0) begin n_fail++; $display("FAIL hit34_memreq: got %0d want 0", r_nreq); end
  endtask

  task automatic test_eviction();
    logic [10:0] addrs [3];
    addrs[0] = 11'd512; addrs[1] = 11'd768; addrs[2] = 11'd512;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      run_req(addrs[i], 0, 0, r_hit, r_nreq, r_maddr, r_lat, r_stable, r_rdylow);
      n_checks++; if (r_hit !== 1'b0 || r_maddr !== addrs[i]) begin
        n_fail++; $display("FAIL evict_%0d: hit %b addr %0d want 0 %0d", i, r_hit, r_maddr, addrs[i]); end
    end
    run_req(11'd34, 0, 0, r_hit, r_nreq, r_maddr, r_lat, r_stable, r_rdylow);
    n_checks++; if (r_hit !== 1'b1) begin n_fail++; $display("FAIL evict_other_line: got %b want 1", r_hit); end
  endtask

  task automatic test_stall();
    @(negedge clk);
    run_req(11'd200, 5, 0, r_hit, r_nreq, r_maddr, r_lat, r_stable, r_rdylow);
    n_checks++; if (r_maddr !== 11'd200 || r_stable !== 1'b1) begin
      n_fail++; $display("FAIL stall_addr: addr %0d stable %b want 200 1", r_maddr, r_stable); end
    n_checks++; if (r_nreq !== 6) begin n_fail++; $display("FAIL stall_valid_cycles: got %0d want 6", r_nreq); end
    n_checks++; if (r_rdylow !== 1'b1) begin n_fail++; $display("FAIL stall_ready_low: got %b want 1", r_rdylow); end
    n_checks++; if (r_lat !== 12 || r_hit !== 1'b0) begin
      n_fail++; $display("FAIL stall_resp: lat %0d hit %b want 12 0", r_lat, r_hit); end
  endtask

  task automatic test_rsp_ignored();
    @(negedge clk);
    bus.mem_rsp_valid = 1'b1;
    repeat (3) @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stray_rsp_busy: got %b want 0", busy); end
    run_req(11'd1000, 0, 0, r_hit, r_nreq, r_maddr, r_lat, r_stable, r_rdylow);
    n_checks++; if (r_hit !== 1'b0 || r_maddr !== 11'd1000 || r_lat !== 7) begin
      n_fail++; $display("FAIL stray_rsp_refill: hit %b addr %0d lat %0d want 0 1000 7", r_hit, r_maddr, r_lat); end
  endtask

  task automatic test_flush();
    int cnt;
    @(negedge clk);
    run_req(11'd136, 0, 0, r_hit, r_nreq, r_maddr, r_lat, r_stable, r_rdylow);
    run_req(11'd200, 0, 2, r_hit, r_nreq, r_maddr, r_lat, r_stable, r_rdylow);
    n_checks++; if (r_hit !== 1'b0 || r_maddr !== 11'd200 || r_lat !== 7) begin
      n_fail++; $display("FAIL flush_mid_refill: hit %b addr %0d lat %0d want 0 200 7", r_hit, r_maddr, r_lat); end
    @(negedge clk);
    n_checks++; if (bus.cpu_req_ready !== 1'b0) begin n_fail++; $display("FAIL flush_pend_ready: got %b want 0", bus.cpu_req_ready); end
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) cnt++;
      else break;
    end
    n_checks++; if (cnt !== 16) begin n_fail++; $display("FAIL flush_cycles: got %0d want 16", cnt); end
    n_checks++; if (bus.cpu_req_ready !== 1'b1) begin n_fail++; $display("FAIL flush_done_ready: got %b want 1", bus.cpu_req_ready); end
    run_req(11'd200, 0, 0, r_hit, r_nreq, r_maddr, r_lat, r_stable, r_rdylow);
    n_checks++; if (r_hit !== 1'b0 || r_nreq !== 1) begin
      n_fail++; $display("FAIL flush_invalidated: hit %b reqs %0d want 0 1", r_hit, r_nreq); end
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    bus.cpu_addr = 11'd34; bus.cpu_req_valid = 1'b1;
    @(negedge clk);
    bus.cpu_req_valid = 1'b0;
    @(negedge clk);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b1;
    repeat (2) @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_pre_busy: got %b want 1", busy); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0 || state_dbg !== 3'd0 || bus.mem_req_valid !== 1'b0 || bus.cpu_resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL abort_outputs: busy %b state %0d mem %b resp %b want 0 0 0 0",
                         busy, state_dbg, bus.mem_req_valid, bus.cpu_resp_valid); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_req(11'd34, 0, 0, r_hit, r_nreq, r_maddr, r_lat, r_stable, r_rdylow);
    n_checks++; if (r_hit !== 1'b0 || r_maddr !== 11'd32 || r_lat !== 7) begin
      n_fail++; $display("FAIL abort_fresh_refill: hit %b addr %0d lat %0d want 0 32 7", r_hit, r_maddr, r_lat); end
  endtask

  task automatic test_stats();
    logic [10:0] trace [10];
    logic        exp_hit [10];
    trace[0] = 11'd34;  trace[1] = 11'd34;  trace[2] = 11'd200; trace[3] = 11'd34;  trace[4] = 11'd512;
    trace[5] = 11'd528; trace[6] = 11'd34;  trace[7] = 11'd200; trace[8] = 11'd768; trace[9] = 11'd34;
    exp_hit[0] = 0; exp_hit[1] = 1; exp_hit[2] = 0; exp_hit[3] = 1; exp_hit[4] = 0;
    exp_hit[5] = 0; exp_hit[6] = 1; exp_hit[7] = 1; exp_hit[8] = 0; exp_hit[9] = 1;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      run_req(trace[i], 0, 0, r_hit, r_nreq, r_maddr, r_lat, r_stable, r_rdylow);
      n_checks++; if (r_hit !== exp_hit[i]) begin
        n_fail++; $display("FAIL trace_%0d_addr%0d: hit %b want %b", i, trace[i], r_hit, exp_hit[i]); end
    end
    @(negedge clk);
`ifdef CACHE_STATS_EN
    n_checks++; if (hit_count !== 16'd5 || miss_count !== 16'd5) begin
      n_fail++; $display("FAIL stats_counts: got %0d/%0d want 5/5", hit_count, miss_count); end
`else
    n_checks++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin
      n_fail++; $display("FAIL stats_tied_off: got %0d/%0d want 0/0", hit_count, miss_count); end
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_hit_miss();
    test_eviction();
    test_stall();
    test_rsp_ignored();
    test_flush();
    test_reset_abort();
    test_stats();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
